// File: rtl/multicycle_control.sv
// Control FSM for the multi-cycle datapath: decodes opcode/funct, sequences
// fetch/decode/execute/memory/writeback, owns the memory handshake and counts retired instructions.
module multicycle_control #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSource,
  output logic [3:0]       ALUSel,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRAV = 6'b000111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLLV = 4'b0011;
  localparam logic [3:0] ALU_SRAV = 4'b0100;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I,
    S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_TRAP
  } state_e;

  state_e           state_q, state_d;
  logic             is_sw_q, is_sw_d;
  logic [CNT_W-1:0] instr_count_q, instr_count_d;
  logic             retire_c;
  logic             r_legal_c;
  logic [3:0]       r_sel_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      is_sw_q       <= 1'b0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      is_sw_q       <= is_sw_d;
      instr_count_q <= instr_count_d;
    end
  end

  // R-type funct decode: ALU operation and legality
  always_comb begin
    r_legal_c = 1'b1;
    r_sel_c   = ALU_ADD;
    case (funct)
      FN_ADD:  r_sel_c = ALU_ADD;
      FN_SUB:  r_sel_c = ALU_SUB;
      FN_SLL:  r_sel_c = ALU_SLL;
      FN_SLLV: r_sel_c = ALU_SLLV;
      FN_SRAV: r_sel_c = ALU_SRAV;
      default: r_legal_c = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    is_sw_d     = is_sw_q;
    retire_c    = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    ALUSel      = ALU_ADD;
    illegal     = 1'b0;
    unique case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        // lw/sw distinction is remembered so MEM_ADDR need not look at opcode
        is_sw_d = (opcode == OP_SW);
        case (opcode)
          OP_RTYPE:     state_d = r_legal_c ? S_EXEC_R : S_TRAP;
          OP_ADDI:      state_d = S_EXEC_I;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_TRAP;
        endcase
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUSel  = r_sel_c;
        state_d = S_WB_R;
      end
      S_WB_R: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (state_q == S_EXEC_I) state_d = S_WB_I;
        else                     state_d = is_sw_q ? S_MEM_WR : S_MEM_RD;
      end
      S_WB_I: begin
        RegWrite = 1'b1;
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) begin
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUSel      = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        retire_c    = 1'b1;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end
      S_TRAP:  illegal = 1'b1;
      default: state_d = S_IDLE;
    endcase
    instr_count_d = retire_c ? instr_count_q + CNT_W'(1) : instr_count_q;
  end

  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed vector bench for multicycle_control: per-cycle table of inputs and
// expected control word / retired count, plus a narrow-counter wrap sequence.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode, funct;
  logic        mem_ready;

  logic        pcw, pcwc, iord, mrd, mwr, irw, rdst, m2r, rwr, asa, ill;
  logic [1:0]  asb, pcs;
  logic [3:0]  asel;
  logic [31:0] cnt;
  logic        pcw2, pcwc2, iord2, mrd2, mwr2, irw2, rdst2, m2r2, rwr2, asa2, ill2;
  logic [1:0]  asb2, pcs2;
  logic [3:0]  asel2;
  logic [1:0]  cnt2;
  logic [18:0] ctrl, ctrl2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  multicycle_control u_dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .PCWrite(pcw), .PCWriteCond(pcwc), .IorD(iord), .MemRead(mrd), .MemWrite(mwr),
    .IRWrite(irw), .RegDst(rdst), .MemtoReg(m2r), .RegWrite(rwr), .ALUSrcA(asa),
    .ALUSrcB(asb), .PCSource(pcs), .ALUSel(asel), .illegal(ill), .instr_count(cnt)
  );

  multicycle_control #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .PCWrite(pcw2), .PCWriteCond(pcwc2), .IorD(iord2), .MemRead(mrd2), .MemWrite(mwr2),
    .IRWrite(irw2), .RegDst(rdst2), .MemtoReg(m2r2), .RegWrite(rwr2), .ALUSrcA(asa2),
    .ALUSrcB(asb2), .PCSource(pcs2), .ALUSel(asel2), .illegal(ill2), .instr_count(cnt2)
  );

  assign ctrl  = {pcw, pcwc, iord, mrd, mwr, irw, rdst, m2r, rwr, asa, asb, pcs, asel, ill};
  assign ctrl2 = {pcw2, pcwc2, iord2, mrd2, mwr2, irw2, rdst2, m2r2, rwr2, asa2, asb2, pcs2, asel2, ill2};

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA}_ALUSrcB_PCSource_ALUSel_illegal
  localparam logic [18:0] E_IDLE  = 19'b0000000000_00_00_0000_0;
  localparam logic [18:0] E_FW    = 19'b0001000000_01_00_0000_0;
  localparam logic [18:0] E_FR    = 19'b1001010000_01_00_0000_0;
  localparam logic [18:0] E_DEC   = 19'b0000000000_11_00_0000_0;
  localparam logic [18:0] E_XADD  = 19'b0000000001_00_00_0000_0;
  localparam logic [18:0] E_XSUB  = 19'b0000000001_00_00_0001_0;
  localparam logic [18:0] E_XSLL  = 19'b0000000001_00_00_0010_0;
  localparam logic [18:0] E_XSLLV = 19'b0000000001_00_00_0011_0;
  localparam logic [18:0] E_XSRAV = 19'b0000000001_00_00_0100_0;
  localparam logic [18:0] E_WBR   = 19'b0000001010_00_00_0000_0;
  localparam logic [18:0] E_XI    = 19'b0000000001_10_00_0000_0;
  localparam logic [18:0] E_WBI   = 19'b0000000010_00_00_0000_0;
  localparam logic [18:0] E_MRD   = 19'b0011000000_00_00_0000_0;
  localparam logic [18:0] E_MWB   = 19'b0000000110_00_00_0000_0;
  localparam logic [18:0] E_MWR   = 19'b0010100000_00_00_0000_0;
  localparam logic [18:0] E_BR    = 19'b0100000001_00_01_0001_0;
  localparam logic [18:0] E_JMP   = 19'b1000000000_00_10_0000_0;
  localparam logic [18:0] E_TRAP  = 19'b0000000000_00_00_0000_1;

  localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011, OP_BEQ = 6'b000100, OP_J = 6'b000010;
  localparam logic [5:0] OP_BAD = 6'b111111;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_SLL = 6'b000000;
  localparam logic [5:0] F_SLLV = 6'b000100, F_SRAV = 6'b000111, F_BAD = 6'b101010;

  typedef struct {
    logic        rst_n;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        mr;
    logic [18:0] exp_ctrl;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic [5:0] o, input logic [5:0] f,
                              input logic m, input logic [18:0] e, input int c);
    vec_t v;
    v.rst_n = r; v.op = o; v.fn = f; v.mr = m; v.exp_ctrl = e; v.exp_cnt = 32'(c);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // apply inputs for one cycle and move to the sampling point before the next edge
  task automatic drive(input logic r, input logic [5:0] o, input logic [5:0] f, input logic m);
    rst_n = r; opcode = o; funct = f; mem_ready = m;
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] exp_small [6];

  initial begin
    // reset and R-type sub
    vecs.push_back(mk(0, OP_R, F_SUB, 1, E_IDLE, 0));
    vecs.push_back(mk(0, OP_R, F_SUB, 1, E_IDLE, 0));
    vecs.push_back(mk(1, OP_R, F_SUB, 1, E_IDLE, 0));
    vecs.push_back(mk(1, OP_R, F_SUB, 1, E_FR, 0));
    vecs.push_back(mk(1, OP_R, F_SUB, 1, E_DEC, 0));
    vecs.push_back(mk(1, OP_R, F_SUB, 1, E_XSUB, 0));
    vecs.push_back(mk(1, OP_R, F_SUB, 1, E_WBR, 0));
    // lw with three wait cycles in MEM_RD
    vecs.push_back(mk(1, OP_LW, F_ADD, 1, E_FR, 1));
    vecs.push_back(mk(1, OP_LW, F_ADD, 1, E_DEC, 1));
    vecs.push_back(mk(1, OP_LW, F_ADD, 1, E_XI, 1));
    vecs.push_back(mk(1, OP_LW, F_ADD, 0, E_MRD, 1));
    vecs.push_back(mk(1, OP_LW, F_ADD, 0, E_MRD, 1));
    vecs.push_back(mk(1, OP_LW, F_ADD, 0, E_MRD, 1));
    vecs.push_back(mk(1, OP_LW, F_ADD, 1, E_MRD, 1));
    vecs.push_back(mk(1, OP_LW, F_ADD, 0, E_MWB, 1));
    // sw with a fetch wait and a write wait
    vecs.push_back(mk(1, OP_SW, F_ADD, 0, E_FW, 2));
    vecs.push_back(mk(1, OP_SW, F_ADD, 1, E_FR, 2));
    vecs.push_back(mk(1, OP_SW, F_ADD, 0, E_DEC, 2));
    vecs.push_back(mk(1, OP_SW, F_ADD, 1, E_XI, 2));
    vecs.push_back(mk(1, OP_SW, F_ADD, 0, E_MWR, 2));
    vecs.push_back(mk(1, OP_SW, F_ADD, 1, E_MWR, 2));
    // beq then j
    vecs.push_back(mk(1, OP_BEQ, F_ADD, 1, E_FR, 3));
    vecs.push_back(mk(1, OP_BEQ, F_ADD, 1, E_DEC, 3));
    vecs.push_back(mk(1, OP_BEQ, F_ADD, 1, E_BR, 3));
    vecs.push_back(mk(1, OP_J, F_ADD, 1, E_FR, 4));
    vecs.push_back(mk(1, OP_J, F_ADD, 1, E_DEC, 4));
    vecs.push_back(mk(1, OP_J, F_ADD, 1, E_JMP, 4));
    // addi, then remaining R-type functs
    vecs.push_back(mk(1, OP_ADDI, F_ADD, 1, E_FR, 5));
    vecs.push_back(mk(1, OP_ADDI, F_ADD, 1, E_DEC, 5));
    vecs.push_back(mk(1, OP_ADDI, F_ADD, 1, E_XI, 5));
    vecs.push_back(mk(1, OP_ADDI, F_ADD, 1, E_WBI, 5));
    vecs.push_back(mk(1, OP_R, F_SLL, 1, E_FR, 6));
    vecs.push_back(mk(1, OP_R, F_SLL, 1, E_DEC, 6));
    vecs.push_back(mk(1, OP_R, F_SLL, 1, E_XSLL, 6));
    vecs.push_back(mk(1, OP_R, F_SLL, 1, E_WBR, 6));
    vecs.push_back(mk(1, OP_R, F_SLLV, 1, E_FR, 7));
    vecs.push_back(mk(1, OP_R, F_SLLV, 1, E_DEC, 7));
    vecs.push_back(mk(1, OP_R, F_SLLV, 1, E_XSLLV, 7));
    vecs.push_back(mk(1, OP_R, F_SLLV, 1, E_WBR, 7));
    vecs.push_back(mk(1, OP_R, F_SRAV, 1, E_FR, 8));
    vecs.push_back(mk(1, OP_R, F_SRAV, 1, E_DEC, 8));
    vecs.push_back(mk(1, OP_R, F_SRAV, 1, E_XSRAV, 8));
    vecs.push_back(mk(1, OP_R, F_SRAV, 1, E_WBR, 8));
    vecs.push_back(mk(1, OP_R, F_ADD, 1, E_FR, 9));
    vecs.push_back(mk(1, OP_R, F_ADD, 1, E_DEC, 9));
    vecs.push_back(mk(1, OP_R, F_ADD, 1, E_XADD, 9));
    vecs.push_back(mk(1, OP_R, F_ADD, 1, E_WBR, 9));
    // unsupported funct traps; held 10 cycles, count frozen, reset clears
    vecs.push_back(mk(1, OP_R, F_BAD, 1, E_FR, 10));
    vecs.push_back(mk(1, OP_R, F_BAD, 1, E_DEC, 10));
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk(1, OP_ADDI, F_ADD, i[0], E_TRAP, 10));
    vecs.push_back(mk(0, OP_R, F_ADD, 1, E_TRAP, 10));
    vecs.push_back(mk(0, OP_R, F_ADD, 1, E_IDLE, 0));
    vecs.push_back(mk(1, OP_BAD, F_ADD, 1, E_IDLE, 0));
    // unknown opcode traps
    vecs.push_back(mk(1, OP_BAD, F_ADD, 1, E_FR, 0));
    vecs.push_back(mk(1, OP_BAD, F_ADD, 1, E_DEC, 0));
    vecs.push_back(mk(1, OP_BAD, F_ADD, 1, E_TRAP, 0));
    vecs.push_back(mk(0, OP_SW, F_ADD, 1, E_TRAP, 0));
    vecs.push_back(mk(1, OP_SW, F_ADD, 1, E_IDLE, 0));
    // reset during a pending store aborts it without retiring
    vecs.push_back(mk(1, OP_SW, F_ADD, 1, E_FR, 0));
    vecs.push_back(mk(1, OP_SW, F_ADD, 1, E_DEC, 0));
    vecs.push_back(mk(1, OP_SW, F_ADD, 1, E_XI, 0));
    vecs.push_back(mk(1, OP_SW, F_ADD, 0, E_MWR, 0));
    vecs.push_back(mk(0, OP_SW, F_ADD, 1, E_MWR, 0));
    vecs.push_back(mk(1, OP_SW, F_ADD, 1, E_IDLE, 0));
    vecs.push_back(mk(1, OP_SW, F_ADD, 1, E_FR, 0));

    rst_n = 1'b0; opcode = OP_R; funct = F_ADD; mem_ready = 1'b1;
    advance();

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].op, vecs[i].fn, vecs[i].mr);
      chk($sformatf("v%0d_ctrl", i), 32'(ctrl), 32'(vecs[i].exp_ctrl));
      chk($sformatf("v%0d_cnt", i), cnt, vecs[i].exp_cnt);
      advance();
    end

    // five addi on the 2-bit counter instance: count wraps 1,2,3,0,1
    exp_small = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    drive(0, OP_ADDI, F_ADD, 1); advance();
    drive(0, OP_ADDI, F_ADD, 1); advance();
    drive(1, OP_ADDI, F_ADD, 1);
    chk("w_idle", 32'(ctrl2), 32'(E_IDLE));
    advance();
    for (int k = 0; k < 5; k++) begin
      drive(1, OP_ADDI, F_ADD, 1);
      chk($sformatf("w%0d_fetch", k), 32'(ctrl2), 32'(E_FR));
      chk($sformatf("w%0d_cnt2", k), 32'(cnt2), 32'(exp_small[k]));
      advance();
      drive(1, OP_ADDI, F_ADD, 1); advance();
      drive(1, OP_ADDI, F_ADD, 1);
      chk($sformatf("w%0d_exec", k), 32'(ctrl2), 32'(E_XI));
      advance();
      drive(1, OP_ADDI, F_ADD, 1);
      chk($sformatf("w%0d_wb", k), 32'(ctrl2), 32'(E_WBI));
      advance();
    end
    drive(1, OP_ADDI, F_ADD, 1);
    chk("w_final_cnt2", 32'(cnt2), 32'(exp_small[5]));
    chk("w_final_cnt32", cnt, 32'd5);
    advance();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style control FSM for the multi-cycle datapath.
- Decodes opcode/funct from the instruction register.
- Sequences fetch/decode/execute/memory/writeback and drives every datapath select, including the 4-bit ALU operation select consumed by the ALU.
- Owns the memory request handshake and counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- mem_ready  in  1  memory completes current read/write this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if ALU Zero
- IorD  out  1  0=PC address, 1=ALUOut address
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  load IR
- RegDst  out  1  1=rd, 0=rt
- MemtoReg  out  1  1=MDR, 0=ALUOut to register file
- RegWrite  out  1  register file write
- ALUSrcA  out  1  0=PC, 1=A register
- ALUSrcB  out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target
- ALUSel  out  4  0000 add, 0001 sub, 0010 sll shamt, 0011 sllv, 0100 srav
- illegal  out  1  sticky illegal-instruction flag
- instr_count  out  CNT_W  retired instructions, wraps

Behaviour:
- State register only; outputs are a pure function of state (plus mem_ready in FETCH). Unlisted outputs are 0 in every state.
- Reset (rst_n=0 at clk edge): state=IDLE, instr_count=0, illegal=0. All outputs are 0 in IDLE. Reset mid-instruction aborts immediately; no pending write completes.
- IDLE -> FETCH unconditionally.
- FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUSel=0000.
  - Holds while mem_ready=0.
  - In the cycle mem_ready=1: IRWrite=1, PCWrite=1, PCSource=00, then -> DECODE.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUSel=0000 (branch target).
  - opcode is sampled only here:
    - 000000 -> EXEC_R if funct legal, else TRAP.
    - 001000 (addi) -> EXEC_I.
    - 100011 (lw) or 101011 (sw) -> MEM_ADDR.
    - 000100 (beq) -> BRANCH.
    - 000010 (j) -> JUMP.
    - anything else -> TRAP.
- EXEC_R:
  - Outputs: ALUSrcA=1, ALUSrcB=00.
  - ALUSel from funct: 100000->0000, 100010->0001, 000000->0010, 000100->0011, 000111->0100.
  - -> WB_R.
- WB_R: RegDst=1, RegWrite=1, MemtoReg=0 -> FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUSel=0000 -> WB_I.
- WB_I: RegDst=0, RegWrite=1, MemtoReg=0 -> FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUSel=0000 -> MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: MemRead=1, IorD=1; hold until mem_ready=1, then -> MEM_WB.
- MEM_WB: RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH.
- MEM_WR: MemWrite=1, IorD=1; hold until mem_ready=1, then -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUSel=0001, PCWriteCond=1, PCSource=01 -> FETCH.
- JUMP: PCWrite=1, PCSource=10 -> FETCH.
- TRAP: illegal=1; all other outputs 0; remains until reset.
- mem_ready is ignored outside FETCH/MEM_RD/MEM_WR. MemRead/MemWrite stay asserted and stable for the whole wait.
- instr_count:
  - +1 on each transition into FETCH from WB_R, WB_I, MEM_WB, MEM_WR, BRANCH, JUMP.
  - Not incremented from IDLE or TRAP.
  - Wraps modulo 2^CNT_W.
- Latencies with mem_ready=1 every request: R-type 4, addi 4, lw 5, sw 4, beq 3, j 3 cycles. Each memory wait cycle adds 1.

Test Plan:
- Reset with rst_n=0 for 2 cycles, mem_ready=1 -> all outputs 0 during reset and IDLE; FETCH asserts MemRead=1, IRWrite=1, PCWrite=1 on the next cycle.
- opcode=000000, funct=100010 (sub) -> EXEC_R drives ALUSel=0001, ALUSrcA=1, ALUSrcB=00; WB_R drives RegWrite=1, RegDst=1; FETCH is re-entered 4 cycles after the prior FETCH; instr_count=1.
- lw (100011) with mem_ready low 3 cycles in MEM_RD -> MemRead=1, IorD=1 held for 4 cycles; then MemtoReg=1, RegWrite=1; total 8 cycles.
- beq then j -> BRANCH shows ALUSel=0001, PCWriteCond=1, PCSource=01; JUMP shows PCWrite=1, PCSource=10; each takes 3 cycles; instr_count advances by 2.
- opcode=000000, funct=101010 (unsupported) -> TRAP, illegal=1 held for 10 cycles; instr_count frozen; rst_n=0 clears illegal to 0.
- CNT_W=2 with 5 addi (001000) -> instr_count sequence 1,2,3,0,1; each addi shows ALUSrcB=10, ALUSel=0000, RegDst=0.
